heartbeat_pulse_gen: RTL and testbench



---
 rtl/heartbeat_pulse_gen.sv | 138 +++++++++++++
 tb/tb_heartbeat_pulse_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/heartbeat_pulse_gen.sv
// Heartbeat "lub-dub" waveform generator: turns a 2-bit heartbeat code into a
// two-pulse beat pattern timed by an external tick, switching codes only at beat starts.
module heartbeat_pulse_gen #(
    parameter int unsigned PERIOD_FAST   = 40,
    parameter int unsigned PERIOD_NORMAL = 75,
    parameter int unsigned PERIOD_SLOW   = 100,
    parameter int unsigned PERIOD_SLEEP  = 120,
    parameter int unsigned LUB_TICKS     = 8,
    parameter int unsigned GAP_TICKS     = 6,
    parameter int unsigned DUB_TICKS     = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic [1:0] heartbeat,
    output logic       beat,
    output logic       beat_strobe,
    output logic [1:0] code_active,
    output logic [7:0] beat_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LUB  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DUB  = 3'd3,
        ST_REST = 3'd4
    } state_t;

    localparam int unsigned BODY_TICKS = LUB_TICKS + GAP_TICKS + DUB_TICKS;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

    // Every period must leave a non-empty rest phase and fit in the phase counter.
    if ((PERIOD_FAST   <= BODY_TICKS) || (PERIOD_NORMAL <= BODY_TICKS) ||
        (PERIOD_SLOW   <= BODY_TICKS) || (PERIOD_SLEEP  <= BODY_TICKS) ||
        (PERIOD_FAST   >  CNT_MAX)    || (PERIOD_NORMAL >  CNT_MAX)    ||
        (PERIOD_SLOW   >  CNT_MAX)    || (PERIOD_SLEEP  >  CNT_MAX)    ||
        (LUB_TICKS == 0) || (GAP_TICKS == 0) || (DUB_TICKS == 0)) begin : g_cfg_check
        $error("heartbeat_pulse_gen: illegal period/phase configuration");
    end

    function automatic logic [CNT_W-1:0] rest_len(input logic [1:0] code);
        case (code)
            2'd0:    rest_len = CNT_W'(PERIOD_FAST   - BODY_TICKS);
            2'd1:    rest_len = CNT_W'(PERIOD_NORMAL - BODY_TICKS);
            2'd2:    rest_len = CNT_W'(PERIOD_SLOW   - BODY_TICKS);
            2'd3:    rest_len = CNT_W'(PERIOD_SLEEP  - BODY_TICKS);
            default: rest_len = CNT_W'(PERIOD_SLEEP  - BODY_TICKS);
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] phase_last_s;
    logic             start_s;
    logic             strobe_s;
    logic             beat_s;
    logic [1:0]       code_s;
    logic [7:0]       count_s;

    // Last counter value of the phase currently playing.
    always_comb begin
        phase_last_s = {CNT_W{1'b0}};
        case (state_r)
            ST_LUB:  phase_last_s = CNT_W'(LUB_TICKS - 1);
            ST_GAP:  phase_last_s = CNT_W'(GAP_TICKS - 1);
            ST_DUB:  phase_last_s = CNT_W'(DUB_TICKS - 1);
            ST_REST: phase_last_s = rest_len(code_active) - {{(CNT_W-1){1'b0}}, 1'b1};
            default: phase_last_s = {CNT_W{1'b0}};
        endcase
    end

    // Next-state, phase counter and beat-start bookkeeping.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        start_s  = 1'b0;
        strobe_s = 1'b0;
        code_s   = code_active;
        count_s  = beat_count;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
        end else if (tick) begin
            if (state_r == ST_IDLE) begin
                state_s = ST_LUB;
                start_s = 1'b1;
            end else if (cnt_r == phase_last_s) begin
                cnt_s = {CNT_W{1'b0}};
                case (state_r)
                    ST_LUB:  state_s = ST_GAP;
                    ST_GAP:  state_s = ST_DUB;
                    ST_DUB:  state_s = ST_REST;
                    ST_REST: begin
                        state_s = ST_LUB;
                        start_s = 1'b1;
                    end
                    default: state_s = ST_IDLE;
                endcase
            end else begin
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            state_s = state_r;
        end
        if (start_s) begin
            cnt_s    = {CNT_W{1'b0}};
            strobe_s = 1'b1;
            code_s   = heartbeat;
            count_s  = beat_count + 8'd1;
        end else begin
            strobe_s = 1'b0;
        end
        beat_s = (state_s == ST_LUB) || (state_s == ST_DUB);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            beat        <= 1'b0;
            beat_strobe <= 1'b0;
            code_active <= 2'd0;
            beat_count  <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            beat        <= beat_s;
            beat_strobe <= strobe_s;
            code_active <= code_s;
            beat_count  <= count_s;
        end
    end

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Self-checking bench for heartbeat_pulse_gen: vector table, directed corner
// sequences and randomized traffic against a beat-position reference model.
module tb_heartbeat_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] heartbeat = 2'd0;
    logic       beat;
    logic       beat_strobe;
    logic [1:0] code_active;
    logic [7:0] beat_count;

    int tests = 0;
    int fails = 0;

    // Reference model: position (in ticks) inside the current beat.
    int m_active = 0;
    int m_pos = 0;
    int m_code = 0;
    int m_count = 0;
    int m_strobe = 0;

    heartbeat_pulse_gen dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .heartbeat(heartbeat),
        .beat(beat), .beat_strobe(beat_strobe), .code_active(code_active),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       tick;
        logic [1:0] hb;
        logic       exp_beat;
        logic       exp_strobe;
        logic [1:0] exp_code;
        logic [7:0] exp_count;
    } vec_t;

    function automatic int period_of(input int code);
        case (code)
            0:       return 40;
            1:       return 75;
            2:       return 100;
            default: return 120;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start();
        m_active = 1;
        m_pos    = 0;
        m_code   = int'(heartbeat);
        m_count  = (m_count + 1) % 256;
        m_strobe = 1;
    endtask

    task automatic model_edge();
        m_strobe = 0;
        if (rst) begin
            m_active = 0; m_pos = 0; m_code = 0; m_count = 0;
        end else if (!en) begin
            m_active = 0; m_pos = 0;
        end else if (tick) begin
            if (m_active == 0) model_start();
            else begin
                m_pos++;
                if (m_pos == period_of(m_code)) model_start();
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        int exp_beat;
        @(posedge clk);
        model_edge();
        #1;
        exp_beat = (m_active != 0 && (m_pos < 8 || (m_pos >= 14 && m_pos < 22))) ? 1 : 0;
        check("model_beat", int'(beat), exp_beat);
        check("model_strobe", int'(beat_strobe), m_strobe);
        check("model_code", int'(code_active), m_code);
        check("model_count", int'(beat_count), m_count);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; tick = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[11];
        int   b[76];
        int   n, ones, c0, lub_end, beat_len, strobes, last;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 8'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd1, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 8'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 2'd1, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 2'd1, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 8'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 8'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0, 8'd1};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; tick = vecs[i].tick; heartbeat = vecs[i].hb;
            cycle();
            check("vec_beat", int'(beat), int'(vecs[i].exp_beat));
            check("vec_strobe", int'(beat_strobe), int'(vecs[i].exp_strobe));
            check("vec_code", int'(code_active), int'(vecs[i].exp_code));
            check("vec_count", int'(beat_count), int'(vecs[i].exp_count));
        end

        // Basic normal beat: 8 high, 6 low, 8 high, 53 low, period 75.
        do_reset();
        en = 1'b1; heartbeat = 2'd1; tick = 1'b1;
        cycle();
        check("first_strobe", int'(beat_strobe), 1);
        check("first_code", int'(code_active), 1);
        b[0] = int'(beat);
        for (int i = 1; i < 76; i++) begin
            cycle();
            b[i] = int'(beat);
        end
        check("second_strobe_at_75", int'(beat_strobe), 1);
        check("count_after_two", int'(beat_count), 2);
        ones = 0; for (int i = 0; i < 8; i++) ones += b[i];
        check("lub_high", ones, 8);
        ones = 0; for (int i = 8; i < 14; i++) ones += b[i];
        check("gap_low", ones, 0);
        ones = 0; for (int i = 14; i < 22; i++) ones += b[i];
        check("dub_high", ones, 8);
        ones = 0; for (int i = 22; i < 75; i++) ones += b[i];
        check("rest_low", ones, 0);

        // Code change at tick 10 of a normal beat: beat keeps 75, next one is 40.
        n = 0;
        do begin
            if (n == 9) heartbeat = 2'd0;
            cycle();
            n++;
        end while (!beat_strobe && n < 300);
        check("changed_beat_len", n, 75);
        check("changed_code", int'(code_active), 0);
        n = 0;
        do begin cycle(); n++; end while (!beat_strobe && n < 300);
        check("fast_beat_len", n, 40);

        // en drop mid-DUB.
        for (int i = 0; i < 15; i++) cycle();
        check("in_dub_high", int'(beat), 1);
        c0 = int'(beat_count);
        en = 1'b0;
        cycle();
        check("en_drop_beat", int'(beat), 0);
        check("en_drop_count", int'(beat_count), c0);
        cycle(); cycle();
        en = 1'b1; tick = 1'b0;
        cycle();
        check("reenable_no_tick", int'(beat_strobe), 0);
        tick = 1'b1;
        cycle();
        check("reenable_strobe", int'(beat_strobe), 1);
        check("reenable_beat", int'(beat), 1);
        check("reenable_count", int'(beat_count), (c0 + 1) % 256);

        // Sparse tick every 4 cycles, sleeping code.
        do_reset();
        en = 1'b1; heartbeat = 2'd3; tick = 1'b1;
        cycle();
        check("sparse_strobe", int'(beat_strobe), 1);
        lub_end = 0; beat_len = 0;
        for (int k = 1; k <= 700; k++) begin
            tick = (k % 4 == 0);
            cycle();
            if (!beat && lub_end == 0) lub_end = k;
            if (beat_strobe) begin
                beat_len = k;
                break;
            end
        end
        check("sparse_lub_cycles", lub_end, 32);
        check("sparse_beat_cycles", beat_len, 480);

        // beat_count wrap over 256 fast beats.
        do_reset();
        en = 1'b1; heartbeat = 2'd0; tick = 1'b1;
        strobes = 0; last = 0;
        for (int cyc = 1; cyc <= 256 * 40 + 100; cyc++) begin
            cycle();
            if (beat_strobe) begin
                strobes++;
                check("wrap_count", int'(beat_count), strobes % 256);
                if (strobes == 255) check("count_255", int'(beat_count), 255);
                if (strobes > 1) check("wrap_spacing", cyc - last, 40);
                last = cyc;
                if (strobes == 256) break;
            end
        end
        check("wrap_strobes_seen", strobes, 256);
        check("wrap_final_zero", int'(beat_count), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 39) != 0);
            tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) heartbeat = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
